tri_inv_seq: RTL and testbench

TRI_INV_SEQ -- requirements
Module: tri_inv_seq

---
 rtl/tri_inv_seq.sv | 143 ++++++++++++++
 tb/tb_tri_inv_seq.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_inv_seq.sv
// Sequencer for a triangular-matrix inverse engine: streams rows from a banked row
// store to the engine and writes the returned inverse columns to a result store.
module tri_inv_seq #(
    parameter int SIZE    = 16,
    parameter int WIDTH   = 64,
    parameter int BANK_W  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic [BANK_W-1:0]                 bank_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              error_o,
    output logic [$clog2(SIZE+1)-1:0]         col_cnt_o,
    output logic                              eng_start_o,
    output logic                              eng_flush_o,
    input  logic [$clog2(SIZE)-1:0]           eng_row_addr_i,
    input  logic                              eng_row_addr_valid_i,
    output logic [SIZE*2*WIDTH-1:0]           eng_row_o,
    output logic [$clog2(SIZE)-1:0]           eng_row_addr_o,
    output logic                              eng_row_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]           eng_col_i,
    input  logic                              eng_col_valid_i,
    output logic                              mem_rd_en_o,
    output logic [BANK_W+$clog2(SIZE)-1:0]    mem_rd_addr_o,
    input  logic [SIZE*2*WIDTH-1:0]           mem_rd_data_i,
    output logic                              res_wr_en_o,
    output logic [BANK_W+$clog2(SIZE)-1:0]    res_wr_addr_o,
    output logic [SIZE*2*WIDTH-1:0]           res_wr_data_o
);

    localparam int AW  = $clog2(SIZE);
    localparam int CW  = $clog2(SIZE+1);
    localparam int DW  = SIZE*2*WIDTH;
    localparam int MW  = BANK_W+AW;
    localparam int WDW = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BANK_W-1:0]   r_bank;
    logic [CW-1:0]       r_col_cnt;
    logic                r_error;
    logic [WDW-1:0]      r_wdog;
    logic                r_row_vld;
    logic [AW-1:0]       r_row_addr;
    logic                r_wr_en;
    logic [MW-1:0]       r_wr_addr;
    logic [DW-1:0]       r_wr_data;

    logic                w_run;
    logic                w_rd_en;
    logic                w_col;
    logic                w_last;
    logic                w_wd_hit;

    assign w_run    = (r_state == S_RUN);
    assign w_rd_en  = w_run && eng_row_addr_valid_i;
    assign w_col    = w_run && eng_col_valid_i;
    assign w_last   = w_col && (r_col_cnt == CW'(SIZE-1));
    // Any engine traffic this cycle restarts the watchdog, so it cannot fire alongside it.
    assign w_wd_hit = w_run && !w_rd_en && !w_col && (r_wdog == WDW'(TIMEOUT-1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_ARM;
            S_ARM:  w_next = abort_i ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort_i)       w_next = S_IDLE;
                else if (w_last)   w_next = S_DONE;
                else if (w_wd_hit) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bank     <= '0;
            r_col_cnt  <= '0;
            r_error    <= 1'b0;
            r_wdog     <= '0;
            r_row_vld  <= 1'b0;
            r_row_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_row_vld  <= w_rd_en;
            r_row_addr <= w_rd_en ? eng_row_addr_i : '0;
            r_wr_en    <= w_col;
            if (w_col) begin
                r_wr_addr <= {r_bank, r_col_cnt[AW-1:0]};
                r_wr_data <= eng_col_i;
                r_col_cnt <= r_col_cnt + 1'b1;
            end
            if (r_state == S_IDLE && start_i) begin
                r_bank    <= bank_i;
                r_col_cnt <= '0;
                r_error   <= 1'b0;
                r_wdog    <= '0;
            end else if (w_run) begin
                r_wdog <= (w_rd_en || w_col) ? '0 : r_wdog + 1'b1;
            end
            if (w_run && w_next == S_ERR) r_error <= 1'b1;
        end
    end

    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);
    assign error_o         = r_error;
    assign col_cnt_o       = r_col_cnt;
    assign eng_start_o     = (r_state == S_ARM);
    assign eng_flush_o     = (r_state == S_ERR) ||
                             (abort_i && (r_state == S_ARM || r_state == S_RUN));

    // Row requests go straight to the store; the 1-cycle read data is tagged on the way back.
    assign mem_rd_en_o     = w_rd_en;
    assign mem_rd_addr_o   = w_rd_en ? {r_bank, eng_row_addr_i} : '0;
    assign eng_row_valid_o = r_row_vld;
    assign eng_row_addr_o  = r_row_addr;
    assign eng_row_o       = r_row_vld ? mem_rd_data_i : '0;

    assign res_wr_en_o     = r_wr_en;
    assign res_wr_addr_o   = r_wr_addr;
    assign res_wr_data_o   = r_wr_data;

endmodule

// File: tb/tb_tri_inv_seq.sv
// Directed bench for tri_inv_seq: row forwarding, column writeback, abort, reset,
// held start and a second short-timeout instance for the watchdog.
module tb_tri_inv_seq;

    localparam int SIZE   = 16;
    localparam int WIDTH  = 64;
    localparam int BANK_W = 2;
    localparam int DW     = SIZE*2*WIDTH;

    int tests = 0;
    int fails = 0;

    logic            clk = 1'b0;
    logic            rst, start, abort, start_wd, abort_wd;
    logic [1:0]      bank;
    logic [3:0]      row_addr_i;
    logic            row_vld_i;
    logic [DW-1:0]   col_i;
    logic            col_vld_i;
    logic [DW-1:0]   mem_rd_data;

    logic            busy, done, err, eng_start, flush;
    logic [4:0]      col_cnt;
    logic [DW-1:0]   row_o;
    logic [3:0]      row_addr_o;
    logic            row_valid_o;
    logic            mem_rd_en;
    logic [5:0]      mem_rd_addr;
    logic            res_wr_en;
    logic [5:0]      res_wr_addr;
    logic [DW-1:0]   res_wr_data;

    logic            wd_busy, wd_done, wd_err, wd_start, wd_flush;
    logic [4:0]      wd_col_cnt;
    logic [DW-1:0]   wd_row_o;
    logic [3:0]      wd_row_addr_o;
    logic            wd_row_valid;
    logic            wd_mem_rd_en;
    logic [5:0]      wd_mem_rd_addr;
    logic            wd_res_wr_en;
    logic [5:0]      wd_res_wr_addr;
    logic [DW-1:0]   wd_res_wr_data;

    always #5 clk = ~clk;

    tri_inv_seq #(.SIZE(SIZE), .WIDTH(WIDTH), .BANK_W(BANK_W), .TIMEOUT(1024)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .bank_i(bank),
        .busy_o(busy), .done_o(done), .error_o(err), .col_cnt_o(col_cnt),
        .eng_start_o(eng_start), .eng_flush_o(flush),
        .eng_row_addr_i(row_addr_i), .eng_row_addr_valid_i(row_vld_i),
        .eng_row_o(row_o), .eng_row_addr_o(row_addr_o), .eng_row_valid_o(row_valid_o),
        .eng_col_i(col_i), .eng_col_valid_i(col_vld_i),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .res_wr_en_o(res_wr_en), .res_wr_addr_o(res_wr_addr), .res_wr_data_o(res_wr_data)
    );

    tri_inv_seq #(.SIZE(SIZE), .WIDTH(WIDTH), .BANK_W(BANK_W), .TIMEOUT(8)) u_wd (
        .clk_i(clk), .rst_i(rst), .start_i(start_wd), .abort_i(abort_wd), .bank_i(bank),
        .busy_o(wd_busy), .done_o(wd_done), .error_o(wd_err), .col_cnt_o(wd_col_cnt),
        .eng_start_o(wd_start), .eng_flush_o(wd_flush),
        .eng_row_addr_i(row_addr_i), .eng_row_addr_valid_i(row_vld_i),
        .eng_row_o(wd_row_o), .eng_row_addr_o(wd_row_addr_o), .eng_row_valid_o(wd_row_valid),
        .eng_col_i(col_i), .eng_col_valid_i(col_vld_i),
        .mem_rd_en_o(wd_mem_rd_en), .mem_rd_addr_o(wd_mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .res_wr_en_o(wd_res_wr_en), .res_wr_addr_o(wd_res_wr_addr), .res_wr_data_o(wd_res_wr_data)
    );

    function automatic logic [DW-1:0] row_pat(input logic [5:0] a);
        logic [63:0] e;
        e = 64'hC0DE_0000_0000_0000 | 64'(a);
        return {(2*SIZE){e}};
    endfunction

    function automatic logic [DW-1:0] col_pat(input int j);
        logic [63:0] e;
        e = 64'hBEEF_0000_0000_0000 | (64'(j) << 4) | 64'(j);
        return {(2*SIZE){e}};
    endfunction

    // Row store model with one cycle of read latency.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? row_pat(mem_rd_addr) : '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        tests++;
        if ({busy, done, err, eng_start, flush, mem_rd_en, res_wr_en, row_valid_o} !== 8'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, err, eng_start, flush, mem_rd_en, res_wr_en, row_valid_o});
        end
        tests++;
        if (col_cnt !== 5'd0 || mem_rd_addr !== 6'd0 || res_wr_addr !== 6'd0) begin
            fails++;
            $display("FAIL reset_cnt: col_cnt=%0d rd_addr=%h wr_addr=%h want all 0",
                     col_cnt, mem_rd_addr, res_wr_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_rows_b2b();
        start = 1'b1;
        bank  = 2'd2;
        step();
        start = 1'b0;
        #1;
        tests++;
        if (eng_start !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL arm_start: eng_start=%b busy=%b want 1 1", eng_start, busy);
        end
        step();
        #1;
        tests++;
        if (eng_start !== 1'b0) begin
            fails++;
            $display("FAIL arm_single: eng_start=%b want 0", eng_start);
        end
        for (int i = 0; i <= 16; i++) begin
            row_vld_i  = (i < 16);
            row_addr_i = 4'(i);
            #1;
            tests++;
            if (i < 16) begin
                if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'(32 + i)) begin
                    fails++;
                    $display("FAIL rows_req[%0d]: en=%b addr=%h want en=1 addr=%h",
                             i, mem_rd_en, mem_rd_addr, 6'(32 + i));
                end
            end else if (mem_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL rows_req_end: en=%b want 0", mem_rd_en);
            end
            tests++;
            if (i > 0) begin
                if (row_valid_o !== 1'b1 || row_addr_o !== 4'(i - 1) ||
                    row_o !== row_pat(6'(32 + i - 1))) begin
                    fails++;
                    $display("FAIL rows_rsp[%0d]: vld=%b tag=%0d data_match=%b want vld=1 tag=%0d data_match=1",
                             i - 1, row_valid_o, row_addr_o, row_o === row_pat(6'(32 + i - 1)), i - 1);
                end
            end else if (row_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL rows_rsp_first: vld=%b want 0", row_valid_o);
            end
            step();
        end
        row_vld_i = 1'b0;
        #1;
        tests++;
        if (row_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rows_rsp_end: vld=%b want 0", row_valid_o);
        end
    endtask

    task automatic test_cols();
        for (int j = 0; j < 16; j++) begin
            col_vld_i = 1'b1;
            col_i     = col_pat(j);
            #1;
            tests++;
            if (col_cnt !== 5'(j) || done !== 1'b0) begin
                fails++;
                $display("FAIL cols_cnt[%0d]: col_cnt=%0d done=%b want %0d 0", j, col_cnt, done, j);
            end
            if (j > 0) begin
                tests++;
                if (res_wr_en !== 1'b1 || res_wr_addr !== 6'(32 + j - 1) ||
                    res_wr_data !== col_pat(j - 1)) begin
                    fails++;
                    $display("FAIL cols_wr[%0d]: en=%b addr=%h data_match=%b want en=1 addr=%h data_match=1",
                             j - 1, res_wr_en, res_wr_addr, res_wr_data === col_pat(j - 1), 6'(32 + j - 1));
                end
            end
            step();
        end
        col_vld_i = 1'b0;
        #1;
        tests++;
        if (res_wr_en !== 1'b1 || res_wr_addr !== 6'h2F || res_wr_data !== col_pat(15)) begin
            fails++;
            $display("FAIL cols_last_wr: en=%b addr=%h want en=1 addr=2f", res_wr_en, res_wr_addr);
        end
        tests++;
        if (done !== 1'b1 || col_cnt !== 5'd16 || busy !== 1'b1) begin
            fails++;
            $display("FAIL cols_done: done=%b col_cnt=%0d busy=%b want 1 16 1", done, col_cnt, busy);
        end
        step();
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || col_cnt !== 5'd16 || res_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL cols_idle: done=%b busy=%b col_cnt=%0d wr_en=%b want 0 0 16 0",
                     done, busy, col_cnt, res_wr_en);
        end
    endtask

    task automatic test_ignore_idle();
        row_vld_i  = 1'b1;
        row_addr_i = 4'd3;
        col_vld_i  = 1'b1;
        col_i      = col_pat(9);
        #1;
        tests++;
        if (mem_rd_en !== 1'b0 || mem_rd_addr !== 6'd0) begin
            fails++;
            $display("FAIL idle_req: en=%b addr=%h want 0 0", mem_rd_en, mem_rd_addr);
        end
        step();
        #1;
        tests++;
        if (row_valid_o !== 1'b0 || res_wr_en !== 1'b0 || col_cnt !== 5'd16) begin
            fails++;
            $display("FAIL idle_col: row_vld=%b wr_en=%b col_cnt=%0d want 0 0 16",
                     row_valid_o, res_wr_en, col_cnt);
        end
        row_vld_i = 1'b0;
        col_vld_i = 1'b0;
    endtask

    task automatic test_abort_last();
        start = 1'b1;
        bank  = 2'd1;
        step();
        start = 1'b0;
        step();
        for (int j = 0; j < 15; j++) begin
            col_vld_i = 1'b1;
            col_i     = col_pat(j);
            step();
        end
        col_i = col_pat(15);
        abort = 1'b1;
        #1;
        tests++;
        if (flush !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_last_flush: flush=%b done=%b want 1 0", flush, done);
        end
        step();
        abort     = 1'b0;
        col_vld_i = 1'b0;
        #1;
        tests++;
        if (res_wr_en !== 1'b1 || res_wr_addr !== 6'h1F || res_wr_data !== col_pat(15)) begin
            fails++;
            $display("FAIL abort_last_wr: en=%b addr=%h want 1 1f", res_wr_en, res_wr_addr);
        end
        tests++;
        if ({busy, done, flush, err} !== 4'b0 || col_cnt !== 5'd16) begin
            fails++;
            $display("FAIL abort_last_idle: busy/done/flush/err=%b col_cnt=%0d want 0000 16",
                     {busy, done, flush, err}, col_cnt);
        end
        step();
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_last_nodone: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_abort_arm();
        start = 1'b1;
        bank  = 2'd0;
        step();
        start = 1'b0;
        abort = 1'b1;
        #1;
        tests++;
        if (flush !== 1'b1 || eng_start !== 1'b1) begin
            fails++;
            $display("FAIL abort_arm_flush: flush=%b eng_start=%b want 1 1", flush, eng_start);
        end
        step();
        abort = 1'b0;
        #1;
        tests++;
        if ({busy, flush, done, err} !== 4'b0) begin
            fails++;
            $display("FAIL abort_arm_idle: busy/flush/done/err=%b want 0000", {busy, flush, done, err});
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        bank  = 2'd3;
        step();
        start = 1'b0;
        step();
        for (int j = 0; j < 5; j++) begin
            col_vld_i = 1'b1;
            col_i     = col_pat(j);
            step();
        end
        col_vld_i  = 1'b0;
        row_vld_i  = 1'b1;
        row_addr_i = 4'd7;
        #1;
        tests++;
        if (col_cnt !== 5'd5 || mem_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: col_cnt=%0d rd_en=%b want 5 1", col_cnt, mem_rd_en);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, err, eng_start, flush, mem_rd_en, res_wr_en, row_valid_o} !== 8'b0) begin
            fails++;
            $display("FAIL rstmid_ctrl: got %b want 00000000",
                     {busy, done, err, eng_start, flush, mem_rd_en, res_wr_en, row_valid_o});
        end
        tests++;
        if (col_cnt !== 5'd0 || mem_rd_addr !== 6'd0 || res_wr_addr !== 6'd0) begin
            fails++;
            $display("FAIL rstmid_cnt: col_cnt=%0d rd_addr=%h wr_addr=%h want 0 0 0",
                     col_cnt, mem_rd_addr, res_wr_addr);
        end
        step();
        rst       = 1'b0;
        row_vld_i = 1'b0;
        start     = 1'b1;
        bank      = 2'd3;
        step();
        start = 1'b0;
        step();
        col_vld_i = 1'b1;
        col_i     = col_pat(7);
        step();
        col_vld_i = 1'b0;
        #1;
        tests++;
        if (res_wr_en !== 1'b1 || res_wr_addr !== 6'h30 || col_cnt !== 5'd1) begin
            fails++;
            $display("FAIL rstmid_restart: wr_en=%b addr=%h col_cnt=%0d want 1 30 1",
                     res_wr_en, res_wr_addr, col_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_start_held();
        int starts;
        starts = 0;
        start  = 1'b1;
        bank   = 2'd0;
        step();
        #1;
        starts += int'(eng_start);
        step();
        for (int j = 0; j < 16; j++) begin
            col_vld_i = 1'b1;
            col_i     = col_pat(j);
            #1;
            starts += int'(eng_start);
            step();
        end
        col_vld_i = 1'b0;
        #1;
        starts += int'(eng_start);
        tests++;
        if (done !== 1'b1 || col_cnt !== 5'd16) begin
            fails++;
            $display("FAIL held_done: done=%b col_cnt=%0d want 1 16", done, col_cnt);
        end
        step();
        #1;
        tests++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || starts != 1) begin
            fails++;
            $display("FAIL held_once: busy=%b eng_start=%b starts=%0d want 0 0 1", busy, eng_start, starts);
        end
        step();
        #1;
        tests++;
        if (eng_start !== 1'b1 || col_cnt !== 5'd0) begin
            fails++;
            $display("FAIL held_rearm: eng_start=%b col_cnt=%0d want 1 0", eng_start, col_cnt);
        end
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_watchdog();
        start_wd = 1'b1;
        bank     = 2'd0;
        step();
        start_wd = 1'b0;
        #1;
        tests++;
        if (wd_start !== 1'b1) begin
            fails++;
            $display("FAIL wd_arm: eng_start=%b want 1", wd_start);
        end
        step();
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++;
            if (wd_err !== 1'b0 || wd_flush !== 1'b0 || wd_busy !== 1'b1) begin
                fails++;
                $display("FAIL wd_run[%0d]: err=%b flush=%b busy=%b want 0 0 1", k, wd_err, wd_flush, wd_busy);
            end
            step();
        end
        #1;
        tests++;
        if (wd_err !== 1'b1 || wd_flush !== 1'b1 || wd_done !== 1'b0) begin
            fails++;
            $display("FAIL wd_fire: err=%b flush=%b done=%b want 1 1 0", wd_err, wd_flush, wd_done);
        end
        step();
        #1;
        tests++;
        if (wd_busy !== 1'b0 || wd_flush !== 1'b0 || wd_err !== 1'b1 || wd_done !== 1'b0) begin
            fails++;
            $display("FAIL wd_idle: busy=%b flush=%b err=%b done=%b want 0 0 1 0",
                     wd_busy, wd_flush, wd_err, wd_done);
        end
        tests++;
        if ({wd_res_wr_en, wd_mem_rd_en, wd_row_valid} !== 3'b0 || wd_col_cnt !== 5'd0 ||
            (|{wd_row_o, wd_row_addr_o, wd_mem_rd_addr, wd_res_wr_addr, wd_res_wr_data}) !== 1'b0) begin
            fails++;
            $display("FAIL wd_quiet: wr_en/rd_en/row_vld=%b col_cnt=%0d want 000 0",
                     {wd_res_wr_en, wd_mem_rd_en, wd_row_valid}, wd_col_cnt);
        end
        start_wd = 1'b1;
        step();
        start_wd = 1'b0;
        #1;
        tests++;
        if (wd_err !== 1'b0 || wd_busy !== 1'b1) begin
            fails++;
            $display("FAIL wd_clear: err=%b busy=%b want 0 1", wd_err, wd_busy);
        end
        abort_wd = 1'b1;
        step();
        abort_wd = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_wd   = 1'b0;
        abort_wd   = 1'b0;
        bank       = 2'd0;
        row_addr_i = 4'd0;
        row_vld_i  = 1'b0;
        col_i      = '0;
        col_vld_i  = 1'b0;
        test_reset();
        test_rows_b2b();
        test_cols();
        test_ignore_idle();
        test_abort_last();
        test_abort_arm();
        test_reset_mid();
        test_start_held();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
